// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direct-mapped table of 2-bit saturating
// counters indexed by PC[IDX_BITS+1:2]. The ID stage gets a combinational
// taken/not-taken answer every cycle; the EX stage trains the table one
// entry per resolved branch. Two saturating performance counters track
// resolved branches and mispredictions.
module branch_predictor #(
   parameter int         IDX_BITS   = 4,
   parameter logic [1:0] INIT_STATE = 2'b10,
   parameter int         CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             Branch_i,
   input  logic [31:0]      PC_i,
   output logic             predict_o,
   input  logic             update_i,
   input  logic [31:0]      update_PC_i,
   input  logic             branch_result_i,
   input  logic             predict_i,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispredict_cnt_o
);

   localparam int ENTRIES = 1 << IDX_BITS;

   // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
   // The upper bit is the prediction.
   logic [1:0]          ctr_table [ENTRIES];
   logic [IDX_BITS-1:0] lookup_idx;
   logic [IDX_BITS-1:0] update_idx;
   logic [CNT_W-1:0]    branch_cnt;
   logic [CNT_W-1:0]    mispredict_cnt;
   logic                mispredicted;

   // PC bits outside the index field carry no information for this table:
   // the byte offset is ignored and the upper bits alias by design (no tags).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PC_i[31:IDX_BITS+2], PC_i[1:0],
                             update_PC_i[31:IDX_BITS+2], update_PC_i[1:0]};

   // Step a 2-bit counter toward the observed outcome, saturating at 00/11.
   function automatic logic [1:0] ctr_next(input logic [1:0] cur,
                                           input logic       taken);
      logic [1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != 2'b11) nxt = cur + 2'b01;
      end else begin
         if (cur != 2'b00) nxt = cur - 2'b01;
      end
      return nxt;
   endfunction

   // Saturating increment for the performance counters: sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign lookup_idx   = PC_i[IDX_BITS+1:2];
   assign update_idx   = update_PC_i[IDX_BITS+1:2];
   assign mispredicted = branch_result_i ^ predict_i;

   // Lookup reads the registered table only, so a same-cycle update to the
   // same entry is seen from the following cycle (no bypass).
   assign predict_o = Branch_i & ctr_table[lookup_idx][1];

   // Table training: one entry per resolved branch; reset restores every entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_table[i] <= INIT_STATE;
         end
      end else if (update_i) begin
         ctr_table[update_idx] <= ctr_next(ctr_table[update_idx], branch_result_i);
      end
   end

   // Performance counters: count every resolved branch and each wrong guess.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (update_i) begin
         branch_cnt <= sat_inc(branch_cnt);
         if (mispredicted) begin
            mispredict_cnt <= sat_inc(mispredict_cnt);
         end
      end
   end

   assign branch_cnt_o     = branch_cnt;
   assign mispredict_cnt_o = mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, a few
// hand-written reset/saturation sequences, then a randomized run compared
// against an integer-level reference model of the predictor.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic        branch;
   logic [31:0] pc;
   logic        predict;
   logic        upd;
   logic [31:0] upc;
   logic        res;
   logic        pred;
   logic [31:0] bc;
   logic [31:0] mc;
   logic        s_predict;
   logic [2:0]  s_bc;
   logic [2:0]  s_mc;

   int n_checks = 0;
   int n_fail   = 0;

   branch_predictor #(.IDX_BITS(4), .INIT_STATE(2'b10), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .Branch_i(branch), .PC_i(pc), .predict_o(predict),
      .update_i(upd), .update_PC_i(upc), .branch_result_i(res), .predict_i(pred),
      .branch_cnt_o(bc), .mispredict_cnt_o(mc));

   // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
   branch_predictor #(.IDX_BITS(4), .INIT_STATE(2'b10), .CNT_W(3)) dut_sat (
      .clk_i(clk), .rst_i(rst), .Branch_i(branch), .PC_i(pc), .predict_o(s_predict),
      .update_i(upd), .update_PC_i(upc), .branch_result_i(res), .predict_i(pred),
      .branch_cnt_o(s_bc), .mispredict_cnt_o(s_mc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          br;
      logic [31:0] pc;
      bit          upd;
      logic [31:0] upc;
      bit          res;
      bit          pred;
      bit          exp_pred;
      int          exp_bc;
      int          exp_mc;
   } vec_t;

   vec_t vecs[16];

   // Reference model: counters as plain integers 0..3, perf counts as longints.
   int    m_tbl[16];
   longint m_bc, m_mc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit br, input logic [31:0] p, input bit u,
                               input logic [31:0] up, input bit r, input bit pr,
                               input bit ep, input int ebc, input int emc);
      vec_t v;
      v.br = br; v.pc = p; v.upd = u; v.upc = up; v.res = r; v.pred = pr;
      v.exp_pred = ep; v.exp_bc = ebc; v.exp_mc = emc;
      return v;
   endfunction

   function automatic int sat7(input int v);
      return (v > 7) ? 7 : v;
   endfunction

   // One cycle: lookup checked before the edge, counters checked after it.
   task automatic apply(input vec_t v, input string tag);
      branch = v.br; pc = v.pc; upd = v.upd; upc = v.upc; res = v.res; pred = v.pred;
      #1;
      check({tag, ".predict"}, predict, v.exp_pred);
      @(posedge clk);
      #1;
      check({tag, ".branch_cnt"}, bc, v.exp_bc);
      check({tag, ".mispredict_cnt"}, mc, v.exp_mc);
      check({tag, ".sat_branch_cnt"}, s_bc, sat7(v.exp_bc));
      check({tag, ".sat_mispredict_cnt"}, s_mc, sat7(v.exp_mc));
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_tbl[i] = 2;
      m_bc = 0;
      m_mc = 0;
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((a / 4) % 16);
   endfunction

   function automatic bit model_predict(input bit br, input logic [31:0] a);
      return br && (m_tbl[model_idx(a)] >= 2);
   endfunction

   function automatic void model_update(input logic [31:0] a, input bit r, input bit pr);
      int i;
      i = model_idx(a);
      if (r) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
      else   m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (r != pr && m_mc < 64'hFFFF_FFFF) m_mc++;
   endfunction

   task automatic rand_cycle(input int n);
      bit exp_p;
      branch = 1'($urandom);
      pc     = $urandom;
      upd    = ($urandom_range(0, 3) != 0);
      upc    = ($urandom_range(0, 3) == 0) ? pc : $urandom;
      res    = 1'($urandom);
      pred   = 1'($urandom);
      #1;
      exp_p = model_predict(branch, pc);
      check($sformatf("rand%0d.predict", n), predict, exp_p);
      check($sformatf("rand%0d.sat_predict", n), s_predict, exp_p);
      @(posedge clk);
      #1;
      if (upd) model_update(upc, res, pred);
      check($sformatf("rand%0d.branch_cnt", n), bc, m_bc[31:0]);
      check($sformatf("rand%0d.mispredict_cnt", n), mc, m_mc[31:0]);
      check($sformatf("rand%0d.sat_branch_cnt", n), s_bc, (m_bc > 7) ? 7 : m_bc);
      check($sformatf("rand%0d.sat_mispredict_cnt", n), s_mc, (m_mc > 7) ? 7 : m_mc);
   endtask

   initial begin
      // Directed vectors after reset (all entries weakly taken).
      // Index: 0x10 -> 4, 0x20 -> 8, 0x04/0x44 -> 1, 0x13 -> 4, 0x22/0x23 -> 8.
      vecs[0]  = mk(1, 32'h10, 0, 32'h0,  0, 0, 1, 0, 0);
      vecs[1]  = mk(1, 32'h10, 1, 32'h10, 0, 1, 1, 1, 1);
      vecs[2]  = mk(1, 32'h10, 1, 32'h10, 0, 0, 0, 2, 1);
      vecs[3]  = mk(1, 32'h10, 1, 32'h10, 0, 0, 0, 3, 1);
      vecs[4]  = mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 4, 2);
      vecs[5]  = mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 5, 3);
      vecs[6]  = mk(1, 32'h10, 0, 32'h0,  0, 0, 1, 5, 3);
      vecs[7]  = mk(0, 32'h20, 1, 32'h20, 0, 1, 0, 6, 4);
      vecs[8]  = mk(1, 32'h20, 1, 32'h20, 1, 0, 0, 7, 5);
      vecs[9]  = mk(1, 32'h20, 0, 32'h0,  0, 0, 1, 7, 5);
      vecs[10] = mk(1, 32'h44, 1, 32'h04, 0, 1, 1, 8, 6);
      vecs[11] = mk(1, 32'h44, 1, 32'h04, 0, 0, 0, 9, 6);
      vecs[12] = mk(1, 32'h44, 0, 32'h0,  0, 0, 0, 9, 6);
      vecs[13] = mk(0, 32'h10, 0, 32'h0,  0, 0, 0, 9, 6);
      vecs[14] = mk(1, 32'h13, 1, 32'h22, 1, 1, 1, 10, 6);
      vecs[15] = mk(1, 32'h23, 0, 32'h0,  0, 0, 1, 10, 6);

      rst = 1'b1; branch = 1'b0; pc = '0; upd = 1'b0; upc = '0; res = 1'b0; pred = 1'b0;
      #2;
      check("reset.branch_cnt", bc, 0);
      check("reset.mispredict_cnt", mc, 0);
      check("reset.predict_nobranch", predict, 0);
      branch = 1'b1; pc = 32'h10;
      #1;
      check("reset.predict_init", predict, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 16; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset between edges; an update held through reset is dropped.
      apply(mk(1, 32'h10, 1, 32'h10, 0, 1, 1, 11, 7), "prerst");
      branch = 1'b1; pc = 32'h10; upd = 1'b0;
      #1;
      check("prerst.predict", predict, 0);
      #2;
      rst = 1'b1;
      #1;
      check("asyncrst.predict", predict, 1);
      check("asyncrst.branch_cnt", bc, 0);
      check("asyncrst.mispredict_cnt", mc, 0);
      pc = 32'h04;
      #1;
      check("asyncrst.predict_alias_entry", predict, 1);
      pc = 32'h10; upd = 1'b1; upc = 32'h10; res = 1'b0; pred = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; upd = 1'b0;
      #1;
      check("rstdrop.predict", predict, 1);
      check("rstdrop.branch_cnt", bc, 0);
      check("rstdrop.mispredict_cnt", mc, 0);

      // Five updates, two of them mispredicted (entry 12 starts weakly taken).
      apply(mk(1, 32'h30, 1, 32'h30, 1, 1, 1, 1, 0), "cnt0");
      apply(mk(1, 32'h30, 1, 32'h30, 1, 0, 1, 2, 1), "cnt1");
      apply(mk(1, 32'h30, 1, 32'h30, 0, 0, 1, 3, 1), "cnt2");
      apply(mk(1, 32'h30, 1, 32'h30, 1, 1, 1, 4, 1), "cnt3");
      apply(mk(1, 32'h30, 1, 32'h30, 0, 1, 1, 5, 2), "cnt4");

      // Push the 3-bit mispredict counter past all-ones; it must hold at 7.
      for (int k = 0; k < 6; k++)
         apply(mk(1, 32'h30, 1, 32'h30, 0, 1, (k == 0), 6 + k, 3 + k), $sformatf("sat%0d", k));
      check("sat.hold_mispredict", s_mc, 3'd7);

      // Randomized run against the reference model from a fresh reset.
      upd = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      for (int n = 0; n < 400; n++) rand_cycle(n);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
